// File: rtl/vga_fb_arbiter.sv
// Framebuffer BRAM arbiter: scanout fetch always wins, CPU accesses wait in a
// one-entry holding register and use free slots; read data is routed by owner tag.
module vga_fb_arbiter #(
  parameter int ADDR_W       = 13,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 64
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              vga_req_i,
  input  logic [ADDR_W-1:0] vga_addr_i,
  output logic [DATA_W-1:0] vga_data_o,
  output logic              vga_valid_o,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_ready_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_rvalid_o,
  output logic              cpu_starved_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {GNT_IDLE, GNT_VGA, GNT_CPU_WR, GNT_CPU_RD} grant_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_VGA, OWN_CPU} owner_e;

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_LIMIT);

  grant_e grant;
  logic   cpu_issue;

  logic              hold_full_q, hold_full_d;
  logic              hold_we_q, hold_we_d;
  logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
  logic [DATA_W-1:0] hold_wdata_q, hold_wdata_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  owner_e            own0_q, own0_d, own1_q, own1_d;
  logic [DATA_W-1:0] vga_data_q, vga_data_d;
  logic              vga_valid_q, vga_valid_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic              cpu_rvalid_q, cpu_rvalid_d;
  logic [7:0]        starve_cnt_q, starve_cnt_d;

  always_comb begin
    grant        = GNT_IDLE;
    hold_full_d  = hold_full_q;
    hold_we_d    = hold_we_q;
    hold_addr_d  = hold_addr_q;
    hold_wdata_d = hold_wdata_q;
    mem_addr_d   = mem_addr_q;
    mem_we_d     = 1'b0;
    mem_wdata_d  = mem_wdata_q;
    own0_d       = OWN_NONE;
    own1_d       = own0_q;
    starve_cnt_d = starve_cnt_q;

    if (vga_req_i) begin
      grant = GNT_VGA;
    end else if (hold_full_q) begin
      grant = hold_we_q ? GNT_CPU_WR : GNT_CPU_RD;
    end

    case (grant)
      GNT_VGA: begin
        mem_addr_d = vga_addr_i;
        own0_d     = OWN_VGA;
      end
      GNT_CPU_WR: begin
        mem_addr_d  = hold_addr_q;
        mem_we_d    = 1'b1;
        mem_wdata_d = hold_wdata_q;
      end
      GNT_CPU_RD: begin
        mem_addr_d = hold_addr_q;
        own0_d     = OWN_CPU;
      end
      default: ;
    endcase

    cpu_issue = (grant == GNT_CPU_WR) || (grant == GNT_CPU_RD);

    // The holding register is only ever empty or issuing, never both full and accepting.
    if (cpu_issue) begin
      hold_full_d  = 1'b0;
      starve_cnt_d = 8'd0;
    end else if (hold_full_q) begin
      if (starve_cnt_q != 8'hFF) starve_cnt_d = starve_cnt_q + 8'd1;
    end else if (cpu_req_i) begin
      hold_full_d  = 1'b1;
      hold_we_d    = cpu_we_i;
      hold_addr_d  = cpu_addr_i;
      hold_wdata_d = cpu_wdata_i;
    end

    vga_valid_d  = (own1_q == OWN_VGA);
    cpu_rvalid_d = (own1_q == OWN_CPU);
    vga_data_d   = vga_valid_d  ? mem_rdata_i : vga_data_q;
    cpu_rdata_d  = cpu_rvalid_d ? mem_rdata_i : cpu_rdata_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hold_full_q  <= 1'b0;
      hold_we_q    <= 1'b0;
      hold_addr_q  <= '0;
      hold_wdata_q <= '0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
      own0_q       <= OWN_NONE;
      own1_q       <= OWN_NONE;
      vga_data_q   <= '0;
      vga_valid_q  <= 1'b0;
      cpu_rdata_q  <= '0;
      cpu_rvalid_q <= 1'b0;
      starve_cnt_q <= 8'd0;
    end else begin
      hold_full_q  <= hold_full_d;
      hold_we_q    <= hold_we_d;
      hold_addr_q  <= hold_addr_d;
      hold_wdata_q <= hold_wdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      own0_q       <= own0_d;
      own1_q       <= own1_d;
      vga_data_q   <= vga_data_d;
      vga_valid_q  <= vga_valid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign vga_data_o    = vga_data_q;
  assign vga_valid_o   = vga_valid_q;
  assign cpu_ready_o   = ~hold_full_q;
  assign cpu_rdata_o   = cpu_rdata_q;
  assign cpu_rvalid_o  = cpu_rvalid_q;
  assign cpu_starved_o = (starve_cnt_q >= STARVE_LIM);
  assign mem_addr_o    = mem_addr_q;
  assign mem_we_o      = mem_we_q;
  assign mem_wdata_o   = mem_wdata_q;

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Arbitrates the single-port framebuffer BRAM between two requesters: scanout fetch from vga_peripheral, and CPU load/store.
- Scanout has the hard pixel deadline and always wins.
- CPU accesses are buffered in a one-entry holding register and issued in free memory slots.
- Read data is routed back to the requester that issued it via a pipelined owner tag.

Parameters:
ADDR_W, 13, framebuffer word address width
DATA_W, 16, framebuffer word width
STARVE_LIMIT, 64, consecutive CPU wait cycles before cpu_starved asserts (1..255)

Ports:
CLK  in  1  system clock (PLL global clock)
RST_N  in  1  asynchronous active-low reset
vga_req  in  1  scanout fetch request, single-cycle strobe
vga_addr  in  ADDR_W  scanout fetch address
vga_data  out  DATA_W  scanout read data
vga_valid  out  1  vga_data valid, one-cycle pulse
cpu_req  in  1  CPU access request
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_ready  out  1  holding register empty; request accepted when cpu_req && cpu_ready
cpu_rdata  out  DATA_W  CPU read data
cpu_rvalid  out  1  cpu_rdata valid, one-cycle pulse
cpu_starved  out  1  CPU request pending for at least STARVE_LIMIT cycles
mem_addr  out  ADDR_W  BRAM address (registered)
mem_we  out  1  BRAM write enable (registered)
mem_wdata  out  DATA_W  BRAM write data (registered)
mem_rdata  in  DATA_W  BRAM read data, valid the cycle after mem_addr is presented

Behaviour:
Reset and clocking:
- Single clock CLK. Reset is asynchronous and active-low on RST_N.
- All outputs reset to 0, except cpu_ready, which resets to 1.
- Holding register, owner pipeline and starvation counter are cleared on reset.
- In-flight reads are discarded on reset; no valid pulse is emitted for them afterwards.

CPU holding register:
- Loads {we, addr, wdata} on CPU accept; cpu_ready falls on the next edge.
- cpu_ready rises again on the edge where the held access is issued.
- A new request can therefore be accepted in the cycle after issue.

Grant (evaluated each cycle):
- vga_req=1 -> GNT_VGA. Issue a read at vga_addr, mem_we=0.
- Otherwise, if the holding register is full -> GNT_CPU_WR or GNT_CPU_RD, per the held cpu_we.
- Otherwise -> IDLE: mem_we=0, mem_addr holds its last value.
- A CPU request accepted in cycle k is issued no earlier than cycle k+1. There is no combinational bypass.

Read pipeline:
- Owner tag: 2-bit shift of {none, vga, cpu}.
- A read issued at edge e returns on data/valid registered at edge e+2.
- vga_valid or cpu_rvalid pulses for exactly one cycle per issued read.
- Back-to-back reads sustain one result per cycle.
- Writes produce no response. The write completes at the edge after issue.

Simultaneous events:
- vga_req together with a held CPU access: VGA issues and the CPU access waits.
- vga_req together with a new cpu_req while the register is empty: the CPU request is accepted into the holding register, VGA issues.

Starvation counter:
- 8-bit, saturating.
- Increments each cycle the holding register is full and not issued.
- Clears on issue.
- cpu_starved = (count >= STARVE_LIMIT). Status only; it does not change priority.

Data-path rules:
- Data is passed through unmodified.
- Addresses are not wrapped or checked.
- mem_wdata is driven only on a CPU write grant; otherwise it holds its last value.

Test Plan:
- Reset behaviour: assert RST_N=0 mid-read (VGA read of 0x0010 in flight) -> all valids 0 immediately, cpu_ready=1; no vga_valid after release.
- CPU write then read: memory idle. CPU write 0x1234 to 0x0100, then read 0x0100 -> cpu_ready low exactly one cycle per access; cpu_rdata=0x1234 with cpu_rvalid two edges after read issue.
- VGA burst: vga_req every cycle for addresses 0..7 -> vga_valid pulses on 8 consecutive cycles, data in address order, latency 2.
- Contention: CPU read of 0x0200 held while a vga_req burst runs 10 cycles -> CPU issued on the first cycle without vga_req; cpu_rvalid two edges later; zero VGA slots lost.
- Starvation: hold a CPU write while vga_req runs continuously for 100 cycles with STARVE_LIMIT=64 -> cpu_starved rises after 64 wait cycles; it clears on the edge the write issues.
- Simultaneous: vga_req and cpu_req in the same cycle, register empty -> VGA issues that cycle, CPU issues the next cycle; both responses are correctly tagged.
